// File: rtl/mpu_writeback_pkg.sv
// Shared MPU data types: element format, matrix geometry and the
// store/writeback state encodings used by the memory-side stages.
package mpu_data_types;
  localparam int unsigned MBITS           = 3;
  localparam int unsigned NBITS           = 3;
  localparam int unsigned MATRIX_REG_BITS = 2;

  typedef logic [31:0] float_sp;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EMIT
  } store_state_e;

  typedef enum logic [2:0] {
    WB_IDLE,
    WB_REQUEST,
    WB_CAPTURE,
    WB_DRAIN,
    WB_DONE
  } wb_state_e;
endpackage

// File: rtl/mpu_wb_fifo.sv
// Synchronous element FIFO; a push into a full FIFO succeeds only when
// a pop frees a slot on the same edge.
module mpu_wb_fifo
  import mpu_data_types::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_push,
  input  float_sp i_push_data,
  input  logic    i_pop,
  output logic    o_full,
  output logic    o_empty,
  output float_sp o_head
);
  localparam int unsigned AW = $clog2(DEPTH);

  float_sp    r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end
endmodule

// File: rtl/mpu_writeback.sv
// Writeback engine: requests a matrix store, buffers the non-stallable
// element stream and drains it to an external write port at base+offset.
module mpu_writeback
  import mpu_data_types::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned CNT_W      = MBITS + NBITS + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid_in,
  input  logic [MATRIX_REG_BITS:0] cmd_reg_addr_in,
  input  logic [ADDR_W-1:0]        cmd_mem_base_in,
  output logic                     busy_out,
  output logic                     store_req_out,
  output logic [MATRIX_REG_BITS:0] mem_store_addr_out,
  input  logic                     mem_store_en_in,
  input  float_sp                  mem_store_element_in,
  output logic                     ext_wr_valid_out,
  input  logic                     ext_wr_ready_in,
  output logic [ADDR_W-1:0]        ext_wr_addr_out,
  output float_sp                  ext_wr_data_out,
  output logic                     done_out,
  output logic [CNT_W-1:0]         elem_count_out,
  output logic                     overflow_err_out
);
  wb_state_e r_state;
  wb_state_e w_next;

  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_wr_off;
  logic [CNT_W-1:0]  r_cap_cnt;
  logic              r_store_req;
  logic              w_accept;
  logic              w_capture;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  float_sp           w_head;

  assign w_accept  = (r_state == WB_IDLE) && cmd_valid_in;
  assign w_capture = mem_store_en_in &&
                     ((r_state == WB_REQUEST) || (r_state == WB_CAPTURE));
  assign w_pop     = !w_empty && ext_wr_ready_in;

  mpu_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_capture),
    .i_push_data(mem_store_element_in),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head     (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= WB_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      WB_IDLE:    if (cmd_valid_in)     w_next = WB_REQUEST;
      WB_REQUEST: if (mem_store_en_in)  w_next = WB_CAPTURE;
      WB_CAPTURE: if (!mem_store_en_in) w_next = WB_DRAIN;
      WB_DRAIN:   if (w_empty)          w_next = WB_DONE;
      WB_DONE:                          w_next = WB_IDLE;
      default:                          w_next = WB_IDLE;
    endcase
  end

  always_comb begin
    busy_out         = (r_state != WB_IDLE);
    done_out         = (r_state == WB_DONE);
    store_req_out    = r_store_req;
    ext_wr_valid_out = !w_empty;
    ext_wr_data_out  = w_empty ? '0 : w_head;
    ext_wr_addr_out  = r_base + r_wr_off;
  end

  // Request is registered off acceptance so it covers exactly the entry cycle of WB_REQUEST.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_store_req        <= 1'b0;
      r_base             <= '0;
      r_wr_off           <= '0;
      r_cap_cnt          <= '0;
      mem_store_addr_out <= '0;
      elem_count_out     <= '0;
      overflow_err_out   <= 1'b0;
    end else begin
      r_store_req <= w_accept;
      if (w_accept) begin
        mem_store_addr_out <= cmd_reg_addr_in;
        r_base             <= cmd_mem_base_in;
        r_wr_off           <= '0;
        r_cap_cnt          <= '0;
        elem_count_out     <= '0;
        overflow_err_out   <= 1'b0;
      end else begin
        if (w_pop)     r_wr_off  <= r_wr_off + 1'b1;
        if (w_capture) r_cap_cnt <= r_cap_cnt + 1'b1;
        if (w_capture && w_full && !w_pop) overflow_err_out <= 1'b1;
        if (w_next == WB_DONE && r_state != WB_DONE) elem_count_out <= r_cap_cnt;
      end
    end
  end
endmodule
